// File: rtl/ariscv_wb_arb_if.sv
// ariscv_wb_arb_if
//   Bundles the writeback arbiter's producer handshakes, the register-file
//   write port and the decode-side forwarding/pending signals.
//   slave  : arbiter side (consumes ALU/load results, drives RF write port)
//   master : surrounding pipeline side (producers, decode, register file)
//   Signals: alu_valid/alu_ready/alu_rd/alu_data, ld_valid/ld_ready/ld_rd/ld_data,
//            we3/a3/wd3, a1/a2, fwd1_hit/fwd2_hit/fwd1_data/fwd2_data,
//            pend1/pend2, lq_count.
interface ariscv_wb_arb_if #(
   parameter int MSB      = 4,
   parameter int REGW     = 32,
   parameter int LQ_DEPTH = 4
);
   localparam int CW = $clog2(LQ_DEPTH) + 1;

   logic            alu_valid;
   logic            alu_ready;
   logic [MSB:0]    alu_rd;
   logic [REGW-1:0] alu_data;
   logic            ld_valid;
   logic            ld_ready;
   logic [MSB:0]    ld_rd;
   logic [REGW-1:0] ld_data;
   logic            we3;
   logic [MSB:0]    a3;
   logic [REGW-1:0] wd3;
   logic [MSB:0]    a1;
   logic [MSB:0]    a2;
   logic            fwd1_hit;
   logic            fwd2_hit;
   logic [REGW-1:0] fwd1_data;
   logic [REGW-1:0] fwd2_data;
   logic            pend1;
   logic            pend2;
   logic [CW-1:0]   lq_count;

   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, a1, a2,
      output alu_ready, ld_ready, we3, a3, wd3,
             fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, pend1, pend2, lq_count
   );

   modport master (
      output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, a1, a2,
      input  alu_ready, ld_ready, we3, a3, wd3,
             fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, pend1, pend2, lq_count
   );
endinterface

// File: rtl/ariscv_wb_arb.sv
// ariscv_wb_arb
//   Writeback arbiter in front of the register file. Merges the single-cycle
//   ALU result stream and a small FIFO of load results (LQ) into one
//   registered RF write port, gives decode forwarding data for the write in
//   flight, and flags decode reads whose destination is still queued.
//   Ports:
//     clk    - rising-edge clock
//     arst_n - asynchronous active-low reset (priority over srst)
//     srst   - synchronous active-high clear
//     bus    - ariscv_wb_arb_if.slave: producer handshakes, RF write port,
//              forwarding/pending outputs and LQ occupancy
module ariscv_wb_arb #(
   parameter int MSB      = 4,
   parameter int REGW     = 32,
   parameter int LQ_DEPTH = 4,
   parameter int STARVE   = 3
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          srst,
   ariscv_wb_arb_if.slave bus
);
   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE + 1);

   logic [MSB:0]    lq_rd_q   [LQ_DEPTH];
   logic [REGW-1:0] lq_data_q [LQ_DEPTH];

   logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            we3_q, we3_d;
   logic [MSB:0]    a3_q, a3_d;
   logic [REGW-1:0] wd3_q, wd3_d;

   logic            nonempty, full, alu_rdy, alu_win, pop, push_enq;
   logic [LQ_DEPTH-1:0] live;
   logic            pend1, pend2;

   // Arbitration, queue bookkeeping and next write-port value
   always_comb begin
      nonempty = (cnt_q != '0);
      full     = (cnt_q == CW'(LQ_DEPTH));
      // A starved head takes the port regardless of the ALU
      alu_rdy  = !(nonempty && (starve_q >= SW'(STARVE)));
      alu_win  = bus.alu_valid && alu_rdy;
      pop      = !alu_win && nonempty;
      // Full blocks the push even if the head pops this cycle; x0 loads are dropped
      push_enq = bus.ld_valid && !full && (bus.ld_rd != '0);

      wp_d = push_enq ? wp_q + 1'b1 : wp_q;
      rp_d = pop      ? rp_q + 1'b1 : rp_q;

      cnt_d = cnt_q;
      if (push_enq && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!push_enq && pop) begin
         cnt_d = cnt_q - 1'b1;
      end

      starve_d = '0;
      if (nonempty && !pop) begin
         starve_d = (starve_q < SW'(STARVE)) ? starve_q + 1'b1 : starve_q;
      end

      we3_d = 1'b0;
      a3_d  = a3_q;
      wd3_d = wd3_q;
      if (alu_win) begin
         we3_d = (bus.alu_rd != '0);
         a3_d  = bus.alu_rd;
         wd3_d = bus.alu_data;
      end else if (pop) begin
         we3_d = (lq_rd_q[rp_q] != '0);
         a3_d  = lq_rd_q[rp_q];
         wd3_d = lq_data_q[rp_q];
      end
   end

   // An entry is live when its distance from the read pointer is below the occupancy
   always_comb begin
      live  = '0;
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         live[i] = (CW'(PW'(PW'(i) - rp_q)) < cnt_q);
         if (live[i] && (lq_rd_q[i] == bus.a1) && (bus.a1 != '0)) pend1 = 1'b1;
         if (live[i] && (lq_rd_q[i] == bus.a2) && (bus.a2 != '0)) pend2 = 1'b1;
      end
   end

   // Queue storage needs no reset: occupancy alone says which slots are meaningful
   always_ff @(posedge clk) begin
      if (push_enq) begin
         lq_rd_q[wp_q]   <= bus.ld_rd;
         lq_data_q[wp_q] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wp_q     <= '0;
         rp_q     <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         we3_q    <= 1'b0;
         a3_q     <= '0;
         wd3_q    <= '0;
      end else if (srst) begin
         wp_q     <= '0;
         rp_q     <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         we3_q    <= 1'b0;
         a3_q     <= '0;
         wd3_q    <= '0;
      end else begin
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         we3_q    <= we3_d;
         a3_q     <= a3_d;
         wd3_q    <= wd3_d;
      end
   end

   assign bus.alu_ready = alu_rdy;
   assign bus.ld_ready  = !full;
   assign bus.we3       = we3_q;
   assign bus.a3        = a3_q;
   assign bus.wd3       = wd3_q;
   assign bus.lq_count  = cnt_q;
   assign bus.pend1     = pend1;
   assign bus.pend2     = pend2;
   assign bus.fwd1_hit  = we3_q && (a3_q == bus.a1) && (bus.a1 != '0);
   assign bus.fwd2_hit  = we3_q && (a3_q == bus.a2) && (bus.a2 != '0);
   assign bus.fwd1_data = wd3_q;
   assign bus.fwd2_data = wd3_q;
endmodule

// File: tb/tb_ariscv_wb_arb.sv
// tb_ariscv_wb_arb
//   Randomised plus directed bench for ariscv_wb_arb. A queue-based reference
//   model predicts handshakes, forwarding and pending flags each cycle and
//   pushes every expected RF write (with its due cycle) into a scoreboard;
//   an independent monitor pops and compares on the falling edge.
module tb_ariscv_wb_arb;
   localparam int MSB    = 4;
   localparam int REGW   = 32;
   localparam int LQD    = 4;
   localparam int STARVE = 3;

   typedef struct {
      logic [MSB:0]    rd;
      logic [REGW-1:0] data;
   } ent_t;

   typedef struct {
      int              cyc;
      logic [MSB:0]    rd;
      logic [REGW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic arst_n;
   logic srst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   ent_t lq_m[$];
   wr_t  sb[$];
   int   st_m;
   bit   m_we3;
   logic [MSB:0]    m_a3;
   logic [REGW-1:0] m_wd3;

   ariscv_wb_arb_if #(.MSB(MSB), .REGW(REGW), .LQ_DEPTH(LQD)) bus ();

   ariscv_wb_arb #(.MSB(MSB), .REGW(REGW), .LQ_DEPTH(LQD), .STARVE(STARVE)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .srst   (srst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      lq_m.delete();
      st_m  = 0;
      m_we3 = 1'b0;
      m_a3  = '0;
      m_wd3 = '0;
   endtask

   task automatic drive(input bit av, input int ard, input logic [31:0] adat,
                        input bit lv, input int lrd, input logic [31:0] ldat,
                        input int ra1, input int ra2);
      bus.alu_valid = av;
      bus.alu_rd    = MSB'(ard);
      bus.alu_data  = adat;
      bus.ld_valid  = lv;
      bus.ld_rd     = MSB'(lrd);
      bus.ld_data   = ldat;
      bus.a1        = MSB'(ra1);
      bus.a2        = MSB'(ra2);
   endtask

   task automatic idle(input int ra1 = 0, input int ra2 = 0);
      drive(0, 0, 0, 0, 0, 0, ra1, ra2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare combinational outputs against the model, then advance the model
   // by the decision the upcoming clock edge will take.
   task automatic commit();
      bit   ardy, lrdy, win_alu, popm, p1, p2;
      ent_t h;
      logic [MSB:0]    wrd;
      logic [REGW-1:0] wdat;
      #1;
      ardy = !(lq_m.size() > 0 && st_m >= STARVE);
      lrdy = (lq_m.size() != LQD);
      p1 = 0;
      p2 = 0;
      foreach (lq_m[i]) begin
         if (bus.a1 != 0 && lq_m[i].rd == bus.a1) p1 = 1;
         if (bus.a2 != 0 && lq_m[i].rd == bus.a2) p2 = 1;
      end
      chk("alu_ready", bus.alu_ready, ardy);
      chk("ld_ready",  bus.ld_ready,  lrdy);
      chk("lq_count",  bus.lq_count,  lq_m.size());
      chk("pend1",     bus.pend1,     p1);
      chk("pend2",     bus.pend2,     p2);
      chk("fwd1_hit",  bus.fwd1_hit,  m_we3 && m_a3 == bus.a1 && bus.a1 != 0);
      chk("fwd2_hit",  bus.fwd2_hit,  m_we3 && m_a3 == bus.a2 && bus.a2 != 0);
      chk("fwd1_data", bus.fwd1_data, m_wd3);
      chk("fwd2_data", bus.fwd2_data, m_wd3);
      if (srst) begin
         model_clear();
         return;
      end
      win_alu = bus.alu_valid && ardy;
      popm    = !win_alu && lq_m.size() > 0;
      if (lq_m.size() == 0 || popm) st_m = 0;
      else if (st_m < STARVE) st_m++;
      if (win_alu || popm) begin
         if (win_alu) begin
            wrd  = bus.alu_rd;
            wdat = bus.alu_data;
         end else begin
            h    = lq_m.pop_front();
            wrd  = h.rd;
            wdat = h.data;
         end
         m_we3 = (wrd != 0);
         m_a3  = wrd;
         m_wd3 = wdat;
         if (wrd != 0) sb.push_back('{cyc: cyc + 1, rd: wrd, data: wdat});
      end else begin
         m_we3 = 1'b0;
      end
      if (bus.ld_valid && lrdy && bus.ld_rd != 0)
         lq_m.push_back('{rd: bus.ld_rd, data: bus.ld_data});
   endtask

   // Asynchronous reset dropped mid-cycle for half a period
   task automatic do_arst();
      @(negedge clk);
      #1;
      arst_n = 1'b0;
      idle();
      #1;
      chk("arst_lq_count", bus.lq_count, 0);
      chk("arst_we3",      bus.we3,      0);
      chk("arst_a3",       bus.a3,       0);
      chk("arst_wd3",      bus.wd3,      0);
      chk("arst_ld_ready", bus.ld_ready, 1);
      model_clear();
      sb.delete();
      @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   // Monitor: every falling edge, pop the write due this cycle (if any)
   initial begin
      wr_t w;
      bit  due;
      forever begin
         @(negedge clk);
         if (arst_n === 1'b1) begin
            due = (sb.size() > 0 && sb[0].cyc <= cyc);
            chk("we3", bus.we3, due);
            if (due) begin
               w = sb.pop_front();
               if (bus.we3 === 1'b1) begin
                  chk("wr_due_cycle", cyc, w.cyc);
                  chk("wr_a3",  bus.a3,  w.rd);
                  chk("wr_wd3", bus.wd3, w.data);
               end
            end
         end
      end
   end

   initial begin
      int k;
      arst_n = 1'b0;
      srst   = 1'b0;
      idle();
      model_clear();
      #3;
      chk("rst_we3",       bus.we3,       0);
      chk("rst_a3",        bus.a3,        0);
      chk("rst_wd3",       bus.wd3,       0);
      chk("rst_lq_count",  bus.lq_count,  0);
      chk("rst_alu_ready", bus.alu_ready, 1);
      chk("rst_ld_ready",  bus.ld_ready,  1);
      @(posedge clk);
      #1;
      arst_n = 1'b1;

      // ALU only, then forward the write to a1
      tick(); drive(1, 5, 32'h11, 0, 0, 0, 5, 0); commit();
      tick(); idle(5, 0); commit();
      tick(); idle(); commit();

      // Single load with an empty LQ
      tick(); drive(0, 0, 0, 1, 7, 32'hcafebabe, 7, 0); commit();
      tick(); idle(7, 7); commit();
      tick(); idle(7, 0); commit();
      tick(); idle(); commit();

      // Starvation: ALU streams while a load waits
      tick(); drive(1, 3, 32'h100, 1, 9, 32'h900d, 9, 0); commit();
      for (int i = 0; i < 7; i++) begin
         tick(); drive(1, 3 + (i % 3), 32'h101 + i, 0, 0, 0, 9, 3); commit();
      end
      tick(); idle(); commit();

      // Fill the LQ while the ALU is busy; hold the next load until accepted
      k = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         drive(1, 1 + (i % 4), 32'h200 + i, k < 6, 10 + k, 32'h3000 + k, 10 + (i % 6), 12);
         if (k < 6 && lq_m.size() != LQD) k++;
         commit();
      end
      for (int i = 0; i < 8; i++) begin tick(); idle(); commit(); end

      // Writes to x0 from both producers
      for (int i = 0; i < 4; i++) begin
         tick(); drive(i % 2, 0, 32'hdead, 1, 0, 32'hbeef, 0, 0); commit();
      end
      tick(); idle(); commit();

      // Asynchronous reset with three loads queued
      for (int i = 0; i < 3; i++) begin
         tick(); drive(1, 2, 32'h40 + i, 1, 20 + i, 32'h500 + i, 20, 21); commit();
      end
      do_arst();
      for (int i = 0; i < 3; i++) begin tick(); idle(20, 21); commit(); end

      // Same with the synchronous clear
      for (int i = 0; i < 3; i++) begin
         tick(); drive(1, 2, 32'h60 + i, 1, 24 + i, 32'h700 + i, 24, 25); commit();
      end
      tick(); idle(24, 25); srst = 1'b1; commit();
      tick(); srst = 1'b0; idle(24, 25); commit();
      for (int i = 0; i < 3; i++) begin tick(); idle(24, 25); commit(); end

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 750 == 749) do_arst();
         tick();
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom(),
               $urandom_range(0, 1), $urandom_range(0, 7), $urandom(),
               $urandom_range(0, 7), $urandom_range(0, 7));
         srst = ($urandom_range(0, 99) == 0);
         commit();
      end
      tick(); srst = 1'b0; idle(); commit();
      for (int i = 0; i < 8; i++) begin tick(); idle(); commit(); end
      @(negedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
